// File: rtl/truth_table_sweeper.sv
// Clocked sweep controller: drives every N-input vector into three function units,
// compares their results per row, streams each row out and keeps sweep statistics.
module truth_table_sweeper #(
    parameter int N      = 2,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2:0]            f_in,
    output logic [N-1:0]          vec_out,
    output logic                  busy,
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic [N-1:0]          row_idx,
    output logic [2:0]            row_f,
    output logic                  row_err,
    output logic                  done,
    output logic [(1<<N)-1:0]     minterm_mask,
    output logic [N:0]            mismatch_cnt,
    output logic                  any_mismatch,
    output logic [N-1:0]          first_bad_row
);

    localparam int              ROWS        = 1 << N;
    localparam logic [N-1:0]    LAST_ROW    = N'(ROWS - 1);
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_EMIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t         state_r;
    logic [N-1:0]   row_r;
    logic [3:0]     settle_cnt_r;
    logic           row_bad_s;

    // The three implementations agree only when all result bits are equal.
    function automatic logic rows_disagree(input logic [2:0] f);
        return (f[0] != f[1]) || (f[1] != f[2]);
    endfunction

    assign row_bad_s = rows_disagree(f_in);

    // Sweep sequencer with registered row stream and summary outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            row_r         <= '0;
            settle_cnt_r  <= 4'd0;
            vec_out       <= '0;
            busy          <= 1'b0;
            row_valid     <= 1'b0;
            row_idx       <= '0;
            row_f         <= 3'b000;
            row_err       <= 1'b0;
            done          <= 1'b0;
            minterm_mask  <= '0;
            mismatch_cnt  <= '0;
            any_mismatch  <= 1'b0;
            first_bad_row <= '0;
        end else begin
            done <= 1'b0;
            // Abort wins over any transfer; partial summaries are kept.
            if (abort && (state_r != ST_IDLE)) begin
                state_r   <= ST_IDLE;
                busy      <= 1'b0;
                row_valid <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            state_r       <= ST_DRIVE;
                            busy          <= 1'b1;
                            row_r         <= '0;
                            settle_cnt_r  <= 4'd0;
                            vec_out       <= '0;
                            minterm_mask  <= '0;
                            mismatch_cnt  <= '0;
                            any_mismatch  <= 1'b0;
                            first_bad_row <= '0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_DRIVE: begin
                        if (settle_cnt_r == SETTLE_LAST) begin
                            state_r <= ST_SAMPLE;
                        end else begin
                            settle_cnt_r <= settle_cnt_r + 4'd1;
                        end
                    end
                    ST_SAMPLE: begin
                        row_f                <= f_in;
                        row_idx              <= row_r;
                        row_err              <= row_bad_s;
                        minterm_mask[row_r]  <= f_in[0];
                        if (row_bad_s) begin
                            mismatch_cnt <= mismatch_cnt + (N+1)'(1);
                            if (!any_mismatch) begin
                                any_mismatch  <= 1'b1;
                                first_bad_row <= row_r;
                            end else begin
                                first_bad_row <= first_bad_row;
                            end
                        end else begin
                            mismatch_cnt <= mismatch_cnt;
                        end
                        row_valid <= 1'b1;
                        state_r   <= ST_EMIT;
                    end
                    ST_EMIT: begin
                        if (row_ready) begin
                            row_valid <= 1'b0;
                            if (row_r == LAST_ROW) begin
                                state_r <= ST_DONE;
                                done    <= 1'b1;
                            end else begin
                                row_r        <= row_r + N'(1);
                                vec_out      <= row_r + N'(1);
                                settle_cnt_r <= 4'd0;
                                state_r      <= ST_DRIVE;
                            end
                        end else begin
                            state_r <= ST_EMIT;
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        busy      <= 1'b0;
                        row_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper (N=2, SETTLE=1) using XOR function units.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, row_ready, pos_kill;
    logic [2:0] f_in;
    logic [1:0] vec_out, row_idx, first_bad_row;
    logic       busy, row_valid, row_err, done, any_mismatch;
    logic [2:0] row_f;
    logic [3:0] minterm_mask;
    logic [2:0] mismatch_cnt;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int accept_cyc = 0;

    // expected row entry: {err, f[2:0], idx[1:0]}
    logic [5:0] exp_q[$];
    logic [5:0] tbl_good [4] = '{6'b0_000_00, 6'b0_111_01, 6'b0_111_10, 6'b0_000_11};
    logic [5:0] tbl_pos0 [4] = '{6'b0_000_00, 6'b1_011_01, 6'b1_011_10, 6'b0_000_11};

    truth_table_sweeper #(.N(2), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f_in(f_in),
        .vec_out(vec_out), .busy(busy), .row_valid(row_valid), .row_ready(row_ready),
        .row_idx(row_idx), .row_f(row_f), .row_err(row_err), .done(done),
        .minterm_mask(minterm_mask), .mismatch_cnt(mismatch_cnt),
        .any_mismatch(any_mismatch), .first_bad_row(first_bad_row)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Function units: expression, sum-of-products, product-of-sums of a XOR b.
    always_comb begin
        f_in[0] = vec_out[1] ^ vec_out[0];
        f_in[1] = (~vec_out[1] & vec_out[0]) | (vec_out[1] & ~vec_out[0]);
        f_in[2] = pos_kill ? 1'b0 : ((vec_out[1] | vec_out[0]) & (~vec_out[1] | ~vec_out[0]));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pops the scoreboard on every accepted row and tracks done pulses.
    always @(negedge clk) begin
        logic [5:0] e;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rst_n && row_valid && row_ready && !abort) begin
            if (exp_q.size() == 0) begin
                check("unexpected row", {row_err, row_f, row_idx}, 64'h0);
                if ({row_err, row_f, row_idx} == 6'b0) check("unexpected row present", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("row_idx", row_idx, e[1:0]);
                check("row_f",   row_f,   e[4:2]);
                check("row_err", row_err, e[5]);
            end
        end
    end

    task automatic push_tbl(input logic [5:0] t [4], input int cnt);
        for (int i = 0; i < cnt; i++) exp_q.push_back(t[i]);
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        accept_cyc = cyc;
    endtask

    task automatic wait_row(input logic [1:0] idx);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            if (row_valid && row_idx == idx) found = 1'b1;
        end
        check("wait row timeout", found, 1'b1);
    endtask

    task automatic wait_done(input int last, input int lat, input string tag);
        for (int i = 0; i < 200 && done_cnt == last; i++) begin
            @(posedge clk); #1;
        end
        check({tag, " done seen"}, done_cnt, last + 1);
        check({tag, " latency"}, done_cyc - accept_cyc, lat);
        check({tag, " busy low"}, busy, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " outputs zero"},
              {vec_out, busy, row_valid, row_idx, row_f, row_err, done,
               minterm_mask, mismatch_cnt, any_mismatch, first_bad_row}, 64'h0);
    endtask

    task automatic check_summary(input string tag, input logic [3:0] mask,
                                 input logic [2:0] cnt, input logic any, input logic [1:0] first);
        check({tag, " minterm_mask"}, minterm_mask, mask);
        check({tag, " mismatch_cnt"}, mismatch_cnt, cnt);
        check({tag, " any_mismatch"}, any_mismatch, any);
        if (any) check({tag, " first_bad_row"}, first_bad_row, first);
        else     check({tag, " first_bad_row"}, first_bad_row, 2'd0);
        check({tag, " queue drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int last;
        bit found;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; row_ready = 1'b1; pos_kill = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        rst_n = 1'b1;

        // S1: all units correct
        push_tbl(tbl_good, 4);
        last = done_cnt; start_pulse(); wait_done(last, 12, "s1");
        check_summary("s1", 4'b0110, 3'd0, 1'b0, 2'd0);

        // S2: PoS unit stuck at zero
        pos_kill = 1'b1;
        push_tbl(tbl_pos0, 4);
        last = done_cnt; start_pulse(); wait_done(last, 12, "s2");
        check_summary("s2", 4'b0110, 3'd2, 1'b1, 2'd1);
        pos_kill = 1'b0;

        // S3: 5-cycle backpressure on row 2
        push_tbl(tbl_good, 4);
        last = done_cnt; start_pulse();
        wait_row(2'd2);
        row_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall valid", row_valid, 1'b1);
            check("stall idx", row_idx, 2'd2);
            check("stall f", row_f, 3'b111);
        end
        row_ready = 1'b1;
        wait_done(last, 17, "s3");
        check_summary("s3", 4'b0110, 3'd0, 1'b0, 2'd0);

        // S4: start while busy is ignored
        push_tbl(tbl_good, 4);
        last = done_cnt; start_pulse();
        wait_row(2'd1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(last, 12, "s4");
        repeat (20) @(posedge clk);
        #1 check("s4 single done", done_cnt, last + 1);
        check("s4 stays idle", busy, 1'b0);
        check_summary("s4", 4'b0110, 3'd0, 1'b0, 2'd0);

        // S5: abort on row 2 with ready high
        push_tbl(tbl_good, 2);
        last = done_cnt; start_pulse();
        wait_row(2'd2);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("s5 busy", busy, 1'b0);
        check("s5 row_valid", row_valid, 1'b0);
        check("s5 mask bits", minterm_mask[2:0], 3'b110);
        repeat (20) @(posedge clk);
        #1 check("s5 no done", done_cnt, last);
        check("s5 queue drained", exp_q.size(), 0);

        // S6: async reset during DRIVE of row 3
        push_tbl(tbl_good, 3);
        last = done_cnt; start_pulse();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            if (busy && !row_valid && vec_out == 2'd3) found = 1'b1;
        end
        check("s6 reach row 3", found, 1'b1);
        #1 rst_n = 1'b0;
        #1 check_zero("s6 async reset");
        @(posedge clk); #1 rst_n = 1'b1;
        check("s6 no done", done_cnt, last);
        check("s6 queue drained", exp_q.size(), 0);

        // S7: clean sweep after reset
        push_tbl(tbl_good, 4);
        last = done_cnt; start_pulse(); wait_done(last, 12, "s7");
        check_summary("s7", 4'b0110, 3'd0, 1'b0, 2'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer that exhaustively drives every input combination of an N-input boolean function into three parallel implementations of that function: direct expression, sum-of-products and product-of-sums. It samples and compares the three results per row and streams each row out over a valid/ready handshake. It accumulates the minterm mask and the mismatch statistics. It sits between a test/control master and the combinational function units, replacing hand-written stimulus sweeps with a clocked, self-checking controller.

## Interface
- `N`, default 2: number of function inputs; legal range 1..6.
- `SETTLE`, default 1: cycles the input vector is held before sampling; legal range 1..15.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset. Fixed decision: one clock; reset is asynchronous and active-low.
- `start` input 1: single-cycle request to begin a sweep. Honoured only in IDLE.
- `abort` input 1: stops the sweep and returns to IDLE.
- `f_in` input 3: results from the function units. Bit 0 is expression, bit 1 is SoP, bit 2 is PoS.
- `vec_out` output N: input vector driven to all three units. Bit N-1 is the MSB (first variable).
- `busy` output 1: high in every state except IDLE.
- `row_valid` output 1: the per-row result is presented.
- `row_ready` input 1: the consumer accepts the row result.
- `row_idx` output N: row index of the presented result.
- `row_f` output 3: sampled `f_in` for that row.
- `row_err` output 1: the three bits of `row_f` are not all equal.
- `done` output 1: one-cycle pulse when the sweep completes.
- `minterm_mask` output 2^N: bit r holds the expression result for row r.
- `mismatch_cnt` output N+1: number of rows with `row_err`. No saturation is needed.
- `any_mismatch` output 1: at least one mismatch occurred in the last sweep.
- `first_bad_row` output N: lowest row with a mismatch. Valid only when `any_mismatch` is high.

## Operation
- States:
  - IDLE: waits for `start`.
  - DRIVE: holds `vec_out` for the settle period.
  - SAMPLE: captures the function results.
  - EMIT: presents the row result to the consumer.
  - DONE: signals completion.
- IDLE:
  - `start`=1 moves to DRIVE on the next edge.
  - The same edge clears `minterm_mask`, `mismatch_cnt`, `any_mismatch` and `first_bad_row`.
  - The same edge sets row=0 and settle counter=0.
- DRIVE:
  - `vec_out`=row; the settle counter increments each cycle.
  - When counter==SETTLE-1, go to SAMPLE.
  - DRIVE therefore lasts exactly SETTLE cycles.
- SAMPLE (1 cycle):
  - Registers `f_in` into `row_f` and sets `minterm_mask[row]`=`f_in[0]`.
  - If the bits are not all equal: `row_err`=1 and `mismatch_cnt`+1.
  - On the first mismatch of the sweep, also set `any_mismatch`=1 and `first_bad_row`=row.
  - Then go to EMIT.
- EMIT:
  - `row_valid`=1; `row_idx`, `row_f` and `row_err` are stable until transfer.
  - A transfer is `row_valid`&`row_ready` at an edge.
  - On transfer, if row==2^N-1, go to DONE. Otherwise row+1, counter=0, go to DRIVE.
- DONE (1 cycle): `done`=1, then IDLE. Summary outputs hold until the next accepted `start`.
- `start` while `busy` is ignored; it does not restart or queue.
- `abort`=1 in any non-IDLE state:
  - Returns to IDLE on the next edge; `row_valid` drops without a transfer; `done` is not pulsed.
  - Partial summary results are retained.
  - `abort` has priority over a simultaneous transfer.
- `vec_out` keeps its last driven value in IDLE and DONE.

## Timing
- Reset values: state IDLE, and every output 0. This includes `vec_out`, `row_idx`, `row_f`, `row_err`, `minterm_mask`, `mismatch_cnt`, `any_mismatch`, `first_bad_row`, `busy`, `row_valid` and `done`.
- Asynchronous reset mid-sweep aborts immediately with no `done` pulse.
- All outputs are registered; none depend combinationally on `row_ready` or `f_in`.
- `f_in` is sampled at the edge ending SAMPLE. It must be stable SETTLE+1 cycles after `vec_out` changes.
- Per-row latency with `row_ready` tied high is SETTLE+2 cycles.
- Total sweep latency: `done` is high in the cycle beginning 2^N·(SETTLE+2) edges after the edge that accepted `start`. For N=2 and SETTLE=1 this is 12 edges.
- `busy` rises on the edge accepting `start` and falls on the edge leaving DONE.
- Backpressure: `row_ready` low stalls EMIT indefinitely, with no data change and no progress.

## Test plan
- XOR units (all three correct), N=2, SETTLE=1, `row_ready`=1, pulse `start` → rows 0..3 stream `row_f` = 000, 111, 111, 000 → `minterm_mask`=4'b0110, `mismatch_cnt`=0, `any_mismatch`=0, `done` 12 edges after start.
- PoS unit forced to constant 0, same stimulus → `row_err` on rows 1 and 2 → `mismatch_cnt`=2, `any_mismatch`=1, `first_bad_row`=1, `minterm_mask`=4'b0110.
- Hold `row_ready` low for 5 cycles while row 2 is presented → `row_valid` stays high with `row_idx`=2 and `row_f` unchanged; the sweep resumes on release and `done` arrives 5 cycles later than in scenario 1.
- Pulse `start` again during row 1 → ignored; the sweep completes normally with one `done` pulse.
- Assert `abort` while EMIT holds row 2 with `row_ready` high on the same edge → next state IDLE, no transfer counted, no `done`, `busy`=0, `minterm_mask` bits 0..2 retained.
- Drop `rst_n` during DRIVE of row 3 → all outputs are 0 asynchronously. After release, a `start` produces a full clean sweep matching scenario 1.
